mul_share_arbiter: RTL

//  Shares one signed_mag_multiplier between NUM_REQ requesters. Round-robin arbitration,

---
 rtl/mul_share_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// ============================================================================
// mul_share_arbiter
//   Round-robin front end sharing one multi-cycle signed multiplier.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mul_share_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  TIMEOUT = 64,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_a_i,
    input  logic [NUM_REQ*8-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   rsp_valid_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [15:0]            rsp_result_o,
    output logic                   rsp_err_o,
    output logic                   mul_start_o,
    output logic [7:0]             mul_a_o,
    output logic [7:0]             mul_b_o,
    input  logic [15:0]            mul_result_i,
    input  logic                   mul_busy_i,
    input  logic                   mul_done_i
);

    localparam int TM_W = $clog2(TIMEOUT);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    logic [2:0]      state_q,      state_d;
    logic [ID_W-1:0] rr_ptr_q,     rr_ptr_d;
    logic [ID_W-1:0] owner_q,      owner_d;
    logic [7:0]      op_a_q,       op_a_d;
    logic [7:0]      op_b_q,       op_b_d;
    logic [TM_W-1:0] timer_q,      timer_d;
    logic            abort_q,      abort_d;
    logic [ID_W-1:0] rsp_id_q,     rsp_id_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic            rsp_err_q,    rsp_err_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] scan_idx;
    logic            grant_w;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // The multiplier has no reset, so never start it unless it looks idle.
    assign grant_w = (state_q == ST_IDLE) && !mul_busy_i && !mul_done_i && grant_found;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        timer_d      = timer_q;
        abort_d      = abort_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_w) begin
                    owner_d   = grant_idx;
                    op_a_d    = req_a_i[int'(grant_idx)*8 +: 8];
                    op_b_d    = req_b_i[int'(grant_idx)*8 +: 8];
                    rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                    rsp_err_d = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                abort_d = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Aborts route through CAPTURE so they respond on the same
                // schedule as a completion arriving on the final wait cycle.
                if (mul_done_i) begin
                    state_d = ST_CAPTURE;
                end else if (timer_q == TM_W'(TIMEOUT-1)) begin
                    abort_d = 1'b1;
                    state_d = ST_CAPTURE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                rsp_id_d     = owner_q;
                rsp_result_d = abort_q ? 16'd0 : mul_result_i;
                rsp_err_d    = abort_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            timer_q      <= '0;
            abort_q      <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            timer_q      <= timer_d;
            abort_q      <= abort_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready_o  = grant_w ? (NUM_REQ'(1) << grant_idx) : '0;
    assign mul_start_o  = (state_q == ST_ISSUE);
    assign mul_a_o      = op_a_q;
    assign mul_b_o      = op_b_q;
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

`default_nettype wire
